// File: rtl/cache_refill_engine.sv
// cache_refill_engine
//
// Memory-side companion to the cache. Turns a line miss into a burst of
// word reads on the external memory port and streams the returned words
// into the cache fill port. Also drains a dirty victim line from the cache
// writeback port as a burst of word writes. Memory read responses cannot
// be stalled, so they land in a small refill FIFO. Reads are only issued
// while a FIFO slot is guaranteed for the response (credit rule).
//
// Ports
//   aclk_i, rst_i          clock, synchronous active-high reset
//   miss_valid_i/_ready_o  line-miss request handshake, miss_addr_i = address in line
//   dirty_i/wb_ready_o     victim word handshake, wb_addr_i = line, wb_data_i = word
//   valid_m_o/cache2mem_ready_i  refill word handshake, mem_data_o = word
//   mem_req_o/mem_gnt_i    memory request handshake (mem_we_o, mem_addr_o, mem_wdata_o)
//   mem_rvalid_i/rdata_i   in-order read responses, never back-pressured
//   busy_o                 engine not idle
//   state_o                current FSM state (debug)
//
// Handshake semantics: a transfer happens on a rising edge where both valid
// (req) and ready (gnt) are high. A requester holds its payload stable until
// the transfer. valid never waits on ready. mem_rvalid_i has no ready and
// must always be accepted.
module cache_refill_engine #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int WORDS_PER_LINE = 8,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                  aclk_i,
  input  logic                  rst_i,
  input  logic                  miss_valid_i,
  input  logic [ADDR_WIDTH-1:0] miss_addr_i,
  output logic                  miss_ready_o,
  input  logic                  dirty_i,
  input  logic [ADDR_WIDTH-1:0] wb_addr_i,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  output logic                  wb_ready_o,
  output logic                  valid_m_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  input  logic                  cache2mem_ready_i,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  busy_o,
  output logic [1:0]            state_o
);

  localparam int OFFSET = $clog2(WORDS_PER_LINE * DATA_WIDTH / 8);
  localparam int BSH    = $clog2(DATA_WIDTH / 8);
  localparam int CW     = $clog2(WORDS_PER_LINE) + 1;
  localparam int PW     = $clog2(FIFO_DEPTH);
  localparam int NW     = PW + 1;
  localparam int NE     = NW + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WB     = 2'd1;
  localparam logic [1:0] S_REFILL = 2'd2;

  localparam logic [CW-1:0] LAST_BEAT = CW'(WORDS_PER_LINE - 1);
  localparam logic [CW-1:0] BEATS     = CW'(WORDS_PER_LINE);
  localparam logic [NE-1:0] DEPTH_EXT = NE'(FIFO_DEPTH);

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [CW-1:0]         beat_q, beat_d;      // wb_beat in WB, req_cnt in REFILL
  logic [CW-1:0]         pop_cnt_q, pop_cnt_d;
  logic [NW-1:0]         outst_q, outst_d;
  logic [NW-1:0]         fifo_cnt_q, fifo_cnt_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];

  logic                  push, pop, rd_grant, credit_ok;
  logic [ADDR_WIDTH-1:0] word_off;

  // Low line-offset bits of the request addresses are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{miss_addr_i[OFFSET-1:0], wb_addr_i[OFFSET-1:0]};

  // Responses already in flight plus words already buffered must leave room.
  assign credit_ok = ({1'b0, outst_q} + {1'b0, fifo_cnt_q}) < DEPTH_EXT;
  assign word_off  = {{(ADDR_WIDTH-CW){1'b0}}, beat_q} << BSH;

  assign busy_o  = (state_q != S_IDLE);
  assign state_o = state_q;

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    beat_d       = beat_q;
    pop_cnt_d    = pop_cnt_q;
    outst_d      = outst_q;
    fifo_cnt_d   = fifo_cnt_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    miss_ready_o = 1'b0;
    wb_ready_o   = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    rd_grant     = 1'b0;

    // Responses outside REFILL are stale (issued before a reset) and dropped.
    push       = (state_q == S_REFILL) && mem_rvalid_i;
    valid_m_o  = (state_q == S_REFILL) && (fifo_cnt_q != '0);
    mem_data_o = valid_m_o ? fifo_mem[rd_ptr_q] : '0;
    pop        = valid_m_o && cache2mem_ready_i;

    case (state_q)
      S_IDLE: begin
        // Writeback wins over a simultaneous miss; the miss stays pending.
        if (dirty_i) begin
          state_d = S_WB;
          base_d  = {wb_addr_i[ADDR_WIDTH-1:OFFSET], {OFFSET{1'b0}}};
          beat_d  = '0;
        end else begin
          miss_ready_o = miss_valid_i;
          if (miss_valid_i) begin
            state_d    = S_REFILL;
            base_d     = {miss_addr_i[ADDR_WIDTH-1:OFFSET], {OFFSET{1'b0}}};
            beat_d     = '0;
            pop_cnt_d  = '0;
            outst_d    = '0;
            fifo_cnt_d = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
          end
        end
      end
      S_WB: begin
        mem_req_o   = dirty_i;
        mem_we_o    = 1'b1;
        mem_addr_o  = base_q + word_off;
        mem_wdata_o = wb_data_i;
        wb_ready_o  = dirty_i && mem_gnt_i;
        if (wb_ready_o) begin
          beat_d = beat_q + CW'(1);
          if (beat_q == LAST_BEAT) state_d = S_IDLE;
        end
      end
      S_REFILL: begin
        mem_req_o  = (beat_q < BEATS) && credit_ok;
        mem_addr_o = base_q + word_off;
        rd_grant   = mem_req_o && mem_gnt_i;
        if (rd_grant) beat_d = beat_q + CW'(1);
        case ({rd_grant, push})
          2'b10:   outst_d = outst_q + NW'(1);
          2'b01:   outst_d = outst_q - NW'(1);
          default: outst_d = outst_q;
        endcase
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
          2'b10:   fifo_cnt_d = fifo_cnt_q + NW'(1);
          2'b01:   fifo_cnt_d = fifo_cnt_q - NW'(1);
          default: fifo_cnt_d = fifo_cnt_q;
        endcase
        if (pop) begin
          pop_cnt_d = pop_cnt_q + CW'(1);
          if (pop_cnt_q == LAST_BEAT) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      beat_q     <= '0;
      pop_cnt_q  <= '0;
      outst_q    <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      beat_q     <= beat_d;
      pop_cnt_q  <= pop_cnt_d;
      outst_q    <= outst_d;
      fifo_cnt_q <= fifo_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the count gates every read of it.
  always_ff @(posedge aclk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= mem_rdata_i;
  end

  // The credit rule makes this unreachable; a hit means a response was lost.
  a_no_overflow: assert property (@(posedge aclk_i) disable iff (rst_i)
    !(push && !pop && (fifo_cnt_q == NW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_cache_refill_engine.sv
`timescale 1ns/1ps
module tb_cache_refill_engine;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int WPL = 8;
  localparam int FD  = 4;
  localparam int LAT = 2;

  // ---------------- clock / reset ----------------
  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic          rst, miss_valid, dirty, ready, gnt, rvalid;
  logic [AW-1:0] miss_addr, wb_addr;
  logic [DW-1:0] wb_data, rdata;
  logic          miss_ready_o, wb_ready_o, valid_m_o, mem_req_o, mem_we_o, busy_o;
  logic [DW-1:0] mem_data_o, mem_wdata_o;
  logic [AW-1:0] mem_addr_o;
  logic [1:0]    state_dbg;

  cache_refill_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WORDS_PER_LINE(WPL), .FIFO_DEPTH(FD)) dut (
    .aclk_i(aclk), .rst_i(rst),
    .miss_valid_i(miss_valid), .miss_addr_i(miss_addr), .miss_ready_o(miss_ready_o),
    .dirty_i(dirty), .wb_addr_i(wb_addr), .wb_data_i(wb_data), .wb_ready_o(wb_ready_o),
    .valid_m_o(valid_m_o), .mem_data_o(mem_data_o), .cache2mem_ready_i(ready),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(gnt), .mem_rvalid_i(rvalid), .mem_rdata_i(rdata),
    .busy_o(busy_o), .state_o(state_dbg)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard state ----------------
  logic [64:0]   exp_req_q[$];  // {we, addr, wdata}
  logic [DW-1:0] exp_q[$];      // refill words in delivery order
  int            resp_due[$];
  logic [DW-1:0] resp_dat[$];

  int            cyc = 0;
  logic          rst_req = 1'b1;
  logic          miss_pending = 1'b0;
  logic [AW-1:0] miss_pend_addr = '0;
  logic          gnt_rand = 1'b0;
  int            ready_hold = 0;
  logic [DW-1:0] wb_words[WPL];
  int            wb_idx = 0;
  logic          wb_active = 1'b0;
  logic          wb_adv = 1'b0;
  logic [15:0]   data_tag = '0;
  logic          chk_lat = 1'b0;
  int            n_gnt = 0;
  int            n_pop = 0;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {data_tag, 16'(((a & 32'h1F) >> 2) + 1)};
  endfunction

  // ---------------- driver: memory, cache and writeback source ----------------
  initial begin
    rst = 1'b1; miss_valid = 1'b0; miss_addr = '0; dirty = 1'b0; wb_addr = '0; wb_data = '0;
    ready = 1'b1; gnt = 1'b0; rvalid = 1'b0; rdata = '0;
    forever begin
      @(posedge aclk); #1;
      cyc++;
      rst        = rst_req;
      miss_valid = miss_pending;
      miss_addr  = miss_pend_addr;
      gnt        = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (ready_hold > 0) begin ready = 1'b0; ready_hold--; end
      else ready = 1'b1;
      if (resp_due.size() > 0 && resp_due[0] == cyc) begin
        rvalid = 1'b1;
        rdata  = resp_dat.pop_front();
        void'(resp_due.pop_front());
      end else begin
        rvalid = 1'b0;
        rdata  = $urandom;
      end
      if (wb_adv) begin wb_idx++; wb_adv = 1'b0; end
      if (wb_idx >= WPL) wb_active = 1'b0;
      dirty = wb_active;
      if (wb_active) wb_data = wb_words[wb_idx];
      else wb_data = '0;
    end
  end

  // ---------------- monitor ----------------
  logic          stall_prev = 1'b0;
  logic [64:0]   stall_val;
  logic          chk_busy = 1'b0, chk_idle = 1'b0, rv_prev = 1'b0;
  logic [AW-1:0] chk_base;

  initial forever begin
    @(negedge aclk);
    if (rst) begin
      stall_prev = 1'b0; chk_busy = 1'b0; chk_idle = 1'b0; rv_prev = 1'b0;
    end else begin
      if (stall_prev)
        check_eq("req_stable", 128'({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o}), 128'({1'b1, stall_val}));
      stall_prev = mem_req_o && !gnt;
      stall_val  = {mem_we_o, mem_addr_o, mem_wdata_o};
      if (chk_busy)
        check_eq("miss_to_req", 128'({busy_o, mem_req_o, mem_we_o, mem_addr_o}), 128'({1'b1, 1'b1, 1'b0, chk_base}));
      chk_busy = 1'b0;
      if (chk_idle) check_eq("idle_after_last_pop", 128'(busy_o), 128'(0));
      chk_idle = 1'b0;
      if (chk_lat && rv_prev) check_eq("rvalid_to_valid_m", 128'(valid_m_o), 128'(1));
      rv_prev = rvalid;
      if (mem_req_o && gnt) begin
        n_gnt++;
        if (exp_req_q.size() == 0) check_eq("unexpected_req", 128'(mem_req_o), 128'(0));
        else check_eq("mem_req", 128'({mem_we_o, mem_addr_o, mem_we_o ? mem_wdata_o : 32'h0}),
                      128'(exp_req_q.pop_front()));
        if (!mem_we_o) begin
          resp_due.push_back(cyc + LAT);
          resp_dat.push_back(mem_word(mem_addr_o));
        end
      end
      if (wb_ready_o) wb_adv = 1'b1;
      if (valid_m_o && ready) begin
        n_pop++;
        if (exp_q.size() == 0) check_eq("unexpected_pop", 128'(valid_m_o), 128'(0));
        else begin
          check_eq("refill_data", 128'(mem_data_o), 128'(exp_q.pop_front()));
          if (exp_q.size() == 0) chk_idle = 1'b1;
        end
      end
      if (miss_valid && miss_ready_o) begin
        miss_pending = 1'b0;
        chk_busy     = 1'b1;
        chk_base     = miss_addr & ~32'h1F;
      end
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic step();
    @(negedge aclk); #2;
  endtask

  task automatic issue_miss(input logic [AW-1:0] a);
    logic [AW-1:0] base;
    base = a & ~32'h1F;
    for (int i = 0; i < WPL; i++) begin
      exp_req_q.push_back({1'b0, base + 32'(4 * i), 32'h0});
      exp_q.push_back({data_tag, 16'(i + 1)});
    end
    miss_pend_addr = a;
    miss_pending   = 1'b1;
  endtask

  task automatic start_wb(input logic [AW-1:0] a);
    logic [AW-1:0] base;
    base = a & ~32'h1F;
    for (int i = 0; i < WPL; i++) begin
      wb_words[i] = $urandom;
      exp_req_q.push_back({1'b1, base + 32'(4 * i), wb_words[i]});
    end
    wb_addr   = a;
    wb_idx    = 0;
    wb_active = 1'b1;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_req_q.size() != 0 || busy_o || miss_pending) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget)
      check_eq("done_timeout", 128'({miss_pending, busy_o, 32'(exp_q.size()), 32'(exp_req_q.size())}), 128'(0));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int k;
    rst_req = 1'b1;
    repeat (4) step();
    rst_req = 1'b0;
    step();
    check_eq("reset_outputs", 128'({busy_o, miss_ready_o, wb_ready_o, valid_m_o, mem_req_o, mem_we_o,
                                    state_dbg, mem_data_o, mem_addr_o, mem_wdata_o}), 128'(0));

    // Clean miss, continuous grants and cache.
    data_tag = 16'h0000;
    chk_lat  = 1'b1;
    issue_miss(32'h44);
    wait_done(100);

    // Cache stalls 12 cycles: credit limit stops reads at FIFO depth.
    data_tag = 16'h0200;
    issue_miss(32'h44);
    ready_hold = 12;
    n_gnt = 0;
    k = 0;
    while (miss_pending && k < 20) begin step(); k++; end
    repeat (11) step();
    check_eq("stall_grants", 128'(n_gnt), 128'(FD));
    check_eq("stall_req_low", 128'(mem_req_o), 128'(0));
    wait_done(100);

    // Writeback and miss together: writeback first, miss held off.
    data_tag = 16'h0300;
    start_wb(32'h80);
    issue_miss(32'h40);
    k = 0;
    step();
    while (wb_active && k < 40) begin
      check_eq("miss_ready_in_wb", 128'(miss_ready_o), 128'(0));
      if (k == 1) check_eq("wb_first_req", 128'({mem_req_o, mem_we_o, mem_addr_o}), 128'({1'b1, 1'b1, 32'h80}));
      step();
      k++;
    end
    wait_done(100);

    // Random grants on both a refill and a writeback.
    gnt_rand = 1'b1;
    data_tag = 16'h0400;
    issue_miss(32'h1C4);
    wait_done(400);
    start_wb(32'h2A0);
    wait_done(400);
    gnt_rand = 1'b0;

    // Reset after three refill words; stale responses must be ignored.
    data_tag = 16'h0500;
    issue_miss(32'h2C0);
    n_pop = 0;
    k = 0;
    while (n_pop < 3 && k < 50) begin step(); k++; end
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    exp_q.delete();
    exp_req_q.delete();
    chk_lat = 1'b0;
    step();
    check_eq("midburst_reset_outputs", 128'({busy_o, miss_ready_o, wb_ready_o, valid_m_o, mem_req_o, mem_we_o,
                                             state_dbg, mem_data_o, mem_addr_o, mem_wdata_o}), 128'(0));
    k = 0;
    while (resp_due.size() > 0 && k < 20) begin
      check_eq("stale_rvalid_ignored", 128'(valid_m_o), 128'(0));
      step();
      k++;
    end
    step();
    data_tag = 16'h0600;
    chk_lat  = 1'b1;
    issue_miss(32'h100);
    wait_done(100);

    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
